match_scorer: RTL and testbench

- Parametrised next-generation score/win tracker for the Pong game core: N-player scoring, configurable target and win-by margin, serve rotation, and a post-point hold that freezes the ball.
- Sits between the ball/collision logic, which issues per-player score pulses, and the display path, which uses update_score to trigger binary-to-BCD conversion.
- Owns the match state machine: idle, serve hold, play, game over.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/win_judge.sv | 49 ++++
 rtl/match_scorer.sv | 169 ++++++++++++++++
 tb/tb_match_scorer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong match/score logic.
//   state_e   : match state machine encoding (idle, serve hold, play, game over)
//   sel_w     : width of an index into n items, never less than 1 bit
//   score_cap : largest value a score register of width w can hold
package pong_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StPlay,
    StOver
  } state_e;

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned score_cap(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/win_judge.sv
// Combinational win check for the player who just scored.
// Ports:
//   scores_i : packed post-increment scores, player i at [i*SCORE_W +: SCORE_W]
//   scorer_i : index of the player who scored this edge
//   win_o    : scorer has reached MAX_SCORE with a lead of at least WIN_BY over
//              every other player, or has hit the score cap (sudden death)
module win_judge
  import pong_pkg::*;
#(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned SCORE_W   = 5,
  parameter int unsigned MAX_SCORE = 11,
  parameter int unsigned WIN_BY    = 2,
  localparam int unsigned SEL_W    = sel_w(N_PLAYERS)
) (
  input  logic [N_PLAYERS*SCORE_W-1:0] scores_i,
  input  logic [SEL_W-1:0]             scorer_i,
  output logic                         win_o
);

  localparam int unsigned Cap = score_cap(SCORE_W);

  logic [SCORE_W-1:0] own;
  logic [SCORE_W-1:0] other;
  logic [SCORE_W-1:0] lead;
  logic               lead_ok;

  always_comb begin
    own = '0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if (scorer_i == SEL_W'(i)) own = scores_i[i*SCORE_W +: SCORE_W];
    end

    lead_ok = 1'b1;
    other   = '0;
    lead    = '0;
    for (int unsigned j = 0; j < N_PLAYERS; j++) begin
      if (scorer_i != SEL_W'(j)) begin
        other = scores_i[j*SCORE_W +: SCORE_W];
        // Clamp at zero so a trailing scorer never wraps to a huge lead.
        lead  = (own > other) ? own - other : '0;
        if (lead < SCORE_W'(WIN_BY)) lead_ok = 1'b0;
      end
    end

    win_o = ((own >= SCORE_W'(MAX_SCORE)) && lead_ok) || (own == SCORE_W'(Cap));
  end

endmodule

// File: rtl/match_scorer.sv
// Match state machine and score keeping for the Pong core.
// Ports:
//   clock, reset  : system clock, asynchronous active-low reset
//   start         : level; begins a new match from idle or game over
//   scored        : one-cycle per-player point pulses from the ball logic
//   scores        : packed scores, player i at [i*SCORE_W +: SCORE_W]
//   winner        : one-hot winner, zero while no one has won
//   game_over     : high once a winner is decided
//   ball_en       : high only while the ball is in play
//   serve_player  : index of the serving player
//   update_score  : one-cycle pulse whenever the scores change (display refresh)
module match_scorer
  import pong_pkg::*;
#(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned SCORE_W     = 5,
  parameter int unsigned MAX_SCORE   = 11,
  parameter int unsigned WIN_BY      = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned SERVE_ROT   = 2,
  localparam int unsigned SEL_W      = sel_w(N_PLAYERS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N_PLAYERS-1:0]         scored,
  output logic [N_PLAYERS*SCORE_W-1:0] scores,
  output logic [N_PLAYERS-1:0]         winner,
  output logic                         game_over,
  output logic                         ball_en,
  output logic [SEL_W-1:0]             serve_player,
  output logic                         update_score
);

  localparam int unsigned Cap   = score_cap(SCORE_W);
  localparam int unsigned HoldW = sel_w(HOLD_CYCLES);
  localparam int unsigned PtW   = sel_w(SERVE_ROT);

  state_e                       state_q, state_d;
  logic [N_PLAYERS*SCORE_W-1:0] scores_q, scores_d, next_scores;
  logic [N_PLAYERS-1:0]         winner_q, winner_d;
  logic [SEL_W-1:0]             serve_q, serve_d;
  logic [PtW-1:0]               pt_q, pt_d;
  logic [HoldW-1:0]             hold_q, hold_d;
  logic                         upd_q, upd_d;
  logic                         over_q, over_d;
  logic                         ball_q, ball_d;

  logic [SEL_W-1:0] pidx;
  logic             found;
  logic             win;

  // Lowest set index takes the point; simultaneous pulses on other bits are dropped.
  always_comb begin
    pidx  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if (scored[i] && !found) begin
        pidx  = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  // Saturating increment of the selected player's score.
  always_comb begin
    next_scores = scores_q;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if ((pidx == SEL_W'(i)) && (scores_q[i*SCORE_W +: SCORE_W] != SCORE_W'(Cap))) begin
        next_scores[i*SCORE_W +: SCORE_W] = scores_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
      end
    end
  end

  win_judge #(
    .N_PLAYERS (N_PLAYERS),
    .SCORE_W   (SCORE_W),
    .MAX_SCORE (MAX_SCORE),
    .WIN_BY    (WIN_BY)
  ) u_win_judge (
    .scores_i (next_scores),
    .scorer_i (pidx),
    .win_o    (win)
  );

  always_comb begin
    state_d  = state_q;
    scores_d = scores_q;
    winner_d = winner_q;
    serve_d  = serve_q;
    pt_d     = pt_q;
    hold_d   = hold_q;
    upd_d    = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          scores_d = '0;
          winner_d = '0;
          serve_d  = '0;
          pt_d     = '0;
          hold_d   = HoldW'(HOLD_CYCLES - 1);
          upd_d    = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (hold_q == '0) state_d = StPlay;
        else hold_d = hold_q - HoldW'(1);
      end
      StPlay: begin
        if (found) begin
          scores_d = next_scores;
          upd_d    = 1'b1;
          if (pt_q == PtW'(SERVE_ROT - 1)) begin
            pt_d    = '0;
            serve_d = (serve_q == SEL_W'(N_PLAYERS - 1)) ? '0 : serve_q + SEL_W'(1);
          end else begin
            pt_d = pt_q + PtW'(1);
          end
          if (win) begin
            for (int unsigned i = 0; i < N_PLAYERS; i++) winner_d[i] = (pidx == SEL_W'(i));
            state_d = StOver;
          end else begin
            hold_d  = HoldW'(HOLD_CYCLES - 1);
            state_d = StHold;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Status flags are registered copies of the next state.
    over_d = (state_d == StOver);
    ball_d = (state_d == StPlay);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      scores_q <= '0;
      winner_q <= '0;
      serve_q  <= '0;
      pt_q     <= '0;
      hold_q   <= '0;
      upd_q    <= 1'b0;
      over_q   <= 1'b0;
      ball_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      scores_q <= scores_d;
      winner_q <= winner_d;
      serve_q  <= serve_d;
      pt_q     <= pt_d;
      hold_q   <= hold_d;
      upd_q    <= upd_d;
      over_q   <= over_d;
      ball_q   <= ball_d;
    end
  end

  assign scores       = scores_q;
  assign winner       = winner_q;
  assign game_over    = over_q;
  assign ball_en      = ball_q;
  assign serve_player = serve_q;
  assign update_score = upd_q;

endmodule

// File: tb/tb_match_scorer.sv
// Bench for match_scorer: a default 2-player instance (a) and a 3-player,
// 4-bit-score, serve-every-point instance (b) share clock and reset.
module tb_match_scorer;

  localparam int AN = 2, AW = 5, AMAX = 11, AWB = 2, AH = 4, AR = 2;
  localparam int BN = 3, BW = 4, BMAX = 11, BWB = 2, BH = 3, BR = 1;

  localparam int F_SC = 0, F_WN = 1, F_OV = 2, F_BL = 3, F_SV = 4, F_UP = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_start = 1'b0, b_start = 1'b0;
  logic [1:0]  a_scored = '0;
  logic [2:0]  b_scored = '0;
  logic [9:0]  a_scores;
  logic [11:0] b_scores;
  logic [1:0]  a_winner;
  logic [2:0]  b_winner;
  logic        a_over, b_over, a_ball, b_ball, a_upd, b_upd;
  logic        a_serve;
  logic [1:0]  b_serve;

  always #5 clock = ~clock;

  match_scorer #(
    .N_PLAYERS(AN), .SCORE_W(AW), .MAX_SCORE(AMAX), .WIN_BY(AWB), .HOLD_CYCLES(AH), .SERVE_ROT(AR)
  ) u_a (
    .clock(clock), .reset(reset), .start(a_start), .scored(a_scored), .scores(a_scores),
    .winner(a_winner), .game_over(a_over), .ball_en(a_ball), .serve_player(a_serve),
    .update_score(a_upd)
  );

  match_scorer #(
    .N_PLAYERS(BN), .SCORE_W(BW), .MAX_SCORE(BMAX), .WIN_BY(BWB), .HOLD_CYCLES(BH), .SERVE_ROT(BR)
  ) u_b (
    .clock(clock), .reset(reset), .start(b_start), .scored(b_scored), .scores(b_scores),
    .winner(b_winner), .game_over(b_over), .ball_en(b_ball), .serve_player(b_serve),
    .update_score(b_upd)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: match rules in plain integers ----------------
  int m_mode [2];  // 0 idle, 1 hold, 2 play, 3 over
  int m_sc   [2][4];
  int m_win  [2];  // -1 = no winner
  int m_pts  [2];  // points played this match
  int m_hold [2];  // frozen cycles still to go
  bit m_upd  [2];

  function automatic int p_n(int k);  return (k == 0) ? AN : BN;    endfunction
  function automatic int p_w(int k);  return (k == 0) ? AW : BW;    endfunction
  function automatic int p_mx(int k); return (k == 0) ? AMAX : BMAX; endfunction
  function automatic int p_wb(int k); return (k == 0) ? AWB : BWB;  endfunction
  function automatic int p_h(int k);  return (k == 0) ? AH : BH;    endfunction
  function automatic int p_r(int k);  return (k == 0) ? AR : BR;    endfunction
  function automatic int p_cap(int k); return (1 << p_w(k)) - 1;    endfunction

  task automatic m_reset(int k);
    m_mode[k] = 0; m_win[k] = -1; m_pts[k] = 0; m_hold[k] = 0; m_upd[k] = 0;
    for (int i = 0; i < 4; i++) m_sc[k][i] = 0;
  endtask

  function automatic bit m_wins(int k, int p);
    int s = m_sc[k][p];
    if (s == p_cap(k)) return 1;
    if (s < p_mx(k)) return 0;
    for (int j = 0; j < p_n(k); j++)
      if (j != p && (s - m_sc[k][j]) < p_wb(k)) return 0;
    return 1;
  endfunction

  task automatic m_step(int k, bit st, logic [3:0] sc);
    int p = -1;
    if (!reset) begin
      m_reset(k);
      return;
    end
    m_upd[k] = 0;
    case (m_mode[k])
      0, 3: if (st) begin
        for (int i = 0; i < 4; i++) m_sc[k][i] = 0;
        m_win[k] = -1; m_pts[k] = 0; m_hold[k] = p_h(k); m_mode[k] = 1; m_upd[k] = 1;
      end
      1: begin
        m_hold[k]--;
        if (m_hold[k] == 0) m_mode[k] = 2;
      end
      default: begin
        for (int i = 0; i < p_n(k); i++) if (sc[i] && p < 0) p = i;
        if (p >= 0) begin
          if (m_sc[k][p] < p_cap(k)) m_sc[k][p]++;
          m_pts[k]++;
          m_upd[k] = 1;
          if (m_wins(k, p)) begin
            m_win[k] = p; m_mode[k] = 3;
          end else begin
            m_hold[k] = p_h(k); m_mode[k] = 1;
          end
        end
      end
    endcase
  endtask

  function automatic logic [31:0] get(int k, int f);
    if (k == 0) begin
      case (f)
        F_SC: return 32'(a_scores);
        F_WN: return 32'(a_winner);
        F_OV: return 32'(a_over);
        F_BL: return 32'(a_ball);
        F_SV: return 32'(a_serve);
        default: return 32'(a_upd);
      endcase
    end else begin
      case (f)
        F_SC: return 32'(b_scores);
        F_WN: return 32'(b_winner);
        F_OV: return 32'(b_over);
        F_BL: return 32'(b_ball);
        F_SV: return 32'(b_serve);
        default: return 32'(b_upd);
      endcase
    end
  endfunction

  task automatic check_model(int k, string tag);
    logic [31:0] sc = 0;
    for (int i = 0; i < p_n(k); i++) sc |= 32'(m_sc[k][i]) << (i * p_w(k));
    chk({tag, "_scores"}, get(k, F_SC), sc);
    chk({tag, "_winner"}, get(k, F_WN), (m_win[k] >= 0) ? (32'd1 << m_win[k]) : 32'd0);
    chk({tag, "_game_over"}, get(k, F_OV), 32'(m_mode[k] == 3));
    chk({tag, "_ball_en"}, get(k, F_BL), 32'(m_mode[k] == 2));
    chk({tag, "_serve"}, get(k, F_SV), 32'((m_pts[k] / p_r(k)) % p_n(k)));
    chk({tag, "_update"}, get(k, F_UP), 32'(m_upd[k]));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    m_step(0, a_start, {2'b00, a_scored});
    m_step(1, b_start, {1'b0, b_scored});
    @(posedge clock);
    #1;
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    m_reset(0);
    m_reset(1);
    for (int k = 0; k < 2; k++)
      for (int f = 0; f < 6; f++) chk("async_reset_zero", get(k, f), 32'd0);
    a_start = 0; b_start = 0; a_scored = '0; b_scored = '0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic start_match(int k);
    if (k == 0) a_start = 1'b1; else b_start = 1'b1;
    cycle();
    a_start = 1'b0; b_start = 1'b0;
    chk("start_update_pulse", get(k, F_UP), 32'd1);
    chk("start_scores_clear", get(k, F_SC), 32'd0);
  endtask

  task automatic wait_ball(int k);
    int n = 0;
    while (get(k, F_BL) != 32'd1 && n < 20) begin
      cycle();
      n++;
    end
    chk("wait_ball_en", get(k, F_BL), 32'd1);
  endtask

  task automatic point(int k, int p);
    wait_ball(k);
    if (k == 0) a_scored = 2'(1 << p); else b_scored = 3'(1 << p);
    cycle();
    a_scored = '0; b_scored = '0;
    chk("point_update", get(k, F_UP), 32'd1);
  endtask

  typedef struct {
    bit         st;
    logic [1:0] sc;
    logic [9:0] scores;
    bit         ball;
    bit         upd;
    bit         serve;
  } vec_t;

  vec_t tab [12];

  initial begin
    // start, scored -> scores, ball_en, update_score, serve_player (instance a)
    tab[0]  = '{1'b1, 2'b11, 10'h000, 1'b0, 1'b1, 1'b0};
    tab[1]  = '{1'b0, 2'b01, 10'h000, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{1'b0, 2'b00, 10'h000, 1'b0, 1'b0, 1'b0};
    tab[3]  = '{1'b0, 2'b00, 10'h000, 1'b0, 1'b0, 1'b0};
    tab[4]  = '{1'b0, 2'b00, 10'h000, 1'b1, 1'b0, 1'b0};
    tab[5]  = '{1'b0, 2'b11, 10'h001, 1'b0, 1'b1, 1'b0};
    tab[6]  = '{1'b0, 2'b00, 10'h001, 1'b0, 1'b0, 1'b0};
    tab[7]  = '{1'b0, 2'b10, 10'h001, 1'b0, 1'b0, 1'b0};
    tab[8]  = '{1'b0, 2'b00, 10'h001, 1'b0, 1'b0, 1'b0};
    tab[9]  = '{1'b0, 2'b00, 10'h001, 1'b1, 1'b0, 1'b0};
    tab[10] = '{1'b0, 2'b10, 10'h021, 1'b0, 1'b1, 1'b1};
    tab[11] = '{1'b1, 2'b00, 10'h021, 1'b0, 1'b0, 1'b1};

    m_reset(0);
    m_reset(1);
    cycle();
    cycle();
    check_model(0, "reset_a");
    check_model(1, "reset_b");
    reset = 1'b1;

    // Start and hold timing, priority, hold-ignored inputs.
    for (int i = 0; i < 12; i++) begin
      a_start  = tab[i].st;
      a_scored = tab[i].sc;
      cycle();
      chk($sformatf("vec%0d_scores", i), get(0, F_SC), 32'(tab[i].scores));
      chk($sformatf("vec%0d_ball_en", i), get(0, F_BL), 32'(tab[i].ball));
      chk($sformatf("vec%0d_update", i), get(0, F_UP), 32'(tab[i].upd));
      chk($sformatf("vec%0d_serve", i), get(0, F_SV), 32'(tab[i].serve));
    end
    a_start = 0; a_scored = '0;

    // Reset during hold aborts the match.
    async_reset();

    // Basic win 11-0.
    start_match(0);
    for (int n = 1; n <= 11; n++) begin
      point(0, 0);
      if (n == 2) chk("win_serve_after2", get(0, F_SV), 32'd1);
      if (n == 4) chk("win_serve_after4", get(0, F_SV), 32'd0);
      if (n == 10) chk("win_not_yet_at10", get(0, F_OV), 32'd0);
    end
    chk("win_scores", get(0, F_SC), 32'd11);
    chk("win_winner", get(0, F_WN), 32'd1);
    chk("win_game_over", get(0, F_OV), 32'd1);
    chk("win_ball_en", get(0, F_BL), 32'd0);
    chk("win_serve", get(0, F_SV), 32'd1);
    a_scored = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("over_scores_held", get(0, F_SC), 32'd11);
      chk("over_no_update", get(0, F_UP), 32'd0);
    end
    a_scored = '0;

    // Deuce from game over.
    start_match(0);
    for (int r = 0; r < 10; r++) begin
      point(0, 0);
      point(0, 1);
    end
    point(0, 0);
    chk("deuce_11_10_scores", get(0, F_SC), (32'd10 << 5) | 32'd11);
    chk("deuce_11_10_nowin", get(0, F_WN), 32'd0);
    chk("deuce_11_10_hold", get(0, F_BL), 32'd0);
    point(0, 1);
    chk("deuce_11_11_scores", get(0, F_SC), (32'd11 << 5) | 32'd11);
    point(0, 0);
    chk("deuce_12_11_nowin", get(0, F_WN), 32'd0);
    chk("deuce_12_11_over", get(0, F_OV), 32'd0);
    point(0, 0);
    chk("deuce_13_11_scores", get(0, F_SC), (32'd11 << 5) | 32'd13);
    chk("deuce_13_11_winner", get(0, F_WN), 32'd1);
    chk("deuce_13_11_over", get(0, F_OV), 32'd1);

    // Simultaneous pulses and hold-ignored pulses.
    start_match(0);
    wait_ball(0);
    a_scored = 2'b11;
    cycle();
    a_scored = '0;
    chk("simul_scores", get(0, F_SC), 32'd1);
    chk("simul_update", get(0, F_UP), 32'd1);
    a_scored = 2'b10;
    cycle();
    chk("simul_single_pulse", get(0, F_UP), 32'd0);
    cycle();
    a_scored = '0;
    chk("hold_ignored_scores", get(0, F_SC), 32'd1);

    // Instance b: reset mid-hold, sudden death at cap, serve every point.
    start_match(1);
    cycle();
    async_reset();
    start_match(1);
    for (int r = 0; r < 14; r++) begin
      point(1, 0);
      point(1, 1);
    end
    chk("sat_14_14_scores", get(1, F_SC), 32'hEE);
    chk("sat_14_14_nowin", get(1, F_WN), 32'd0);
    point(1, 1);
    chk("sat_cap_scores", get(1, F_SC), 32'hFE);
    chk("sat_cap_winner", get(1, F_WN), 32'd2);
    chk("sat_cap_over", get(1, F_OV), 32'd1);

    start_match(1);
    point(1, 0);
    chk("rot_serve_1", get(1, F_SV), 32'd1);
    point(1, 1);
    chk("rot_serve_2", get(1, F_SV), 32'd2);
    point(1, 2);
    chk("rot_serve_0", get(1, F_SV), 32'd0);
    chk("rot_scores", get(1, F_SC), 32'h111);

    // Random traffic on both instances against the model.
    for (int c = 0; c < 2500; c++) begin
      a_start  = ($urandom_range(0, 15) == 0);
      b_start  = ($urandom_range(0, 15) == 0);
      a_scored = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b_scored = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 599) == 0) async_reset();
      else cycle();
      check_model(0, "rnd_a");
      check_model(1, "rnd_b");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
